// File: rtl/adc_pkg.sv
// adc_pkg: shared types and constants for the printhead temperature ADC scheduler.
//   state_e  - scan FSM state encoding
//   CH_PH/HS - adc_chsel encodings
//   ADC_W    - raw conversion width, VAL_W - published result width
//   sat_add  - saturating VAL_W-bit adder used for the hysteresis threshold
package adc_pkg;

  localparam int unsigned ADC_W = 12;
  localparam int unsigned VAL_W = 16;

  localparam logic CH_PH = 1'b0;
  localparam logic CH_HS = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    PUBLISH = 3'd4
  } state_e;

  // a + b clamped to all-ones on carry out
  function automatic logic [VAL_W-1:0] sat_add(input logic [VAL_W-1:0] a,
                                               input logic [VAL_W-1:0] b);
    logic [VAL_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[VAL_W] ? {VAL_W{1'b1}} : sum[VAL_W-1:0];
  endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// adc_tick_gen: free-running scan-rate divider.
//   clk48mhz - clock
//   rstn     - async active-low reset
//   tick     - registered one-cycle pulse, once every SAMPLE_DIV cycles
module adc_tick_gen #(
  parameter int unsigned SAMPLE_DIV = 48000
) (
  input  logic clk48mhz,
  input  logic rstn,
  output logic tick
);

  localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             wrap_c;

  assign wrap_c = (cnt == CNT_W'(SAMPLE_DIV - 1));

  // counter 0..SAMPLE_DIV-1, tick follows the wrap by one register stage
  always_ff @(posedge clk48mhz or negedge rstn) begin
    if (!rstn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= wrap_c ? '0 : cnt + CNT_W'(1);
      tick <= wrap_c;
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: conversion scheduler for the printhead temperature ADC.
// Paces conversions from the scan tick, alternates printhead/heatsink rounds,
// sequences the SPI shifter, averages 2**AVG_LOG2 samples per round and
// maintains the hysteretic heater-demand flag.
//   clk48mhz, rstn            - clock, async active-low reset
//   enable                    - scan enable (sampled in IDLE only)
//   err_clr                   - clears timeout_err / overrun_err
//   conv_start                - one-cycle start pulse to the shifter
//   conv_done, conv_data      - shifter completion pulse and raw code
//   adc_chsel                 - 0 printhead, 1 heatsink
//   adc_value, adc_hs_value   - printhead / heatsink averages
//   ph_valid, hs_valid        - one-cycle update strobes
//   adc_setpoint, below       - printhead threshold and heater demand
//   timeout_err, overrun_err  - sticky error flags
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV  = 48000,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned SETTLE_CYC  = 96,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned HS_EVERY    = 8,
  parameter int unsigned HYST        = 16
) (
  input  logic             clk48mhz,
  input  logic             rstn,
  input  logic             enable,
  input  logic             err_clr,
  output logic             conv_start,
  input  logic             conv_done,
  input  logic [ADC_W-1:0] conv_data,
  output logic             adc_chsel,
  output logic [VAL_W-1:0] adc_value,
  output logic [VAL_W-1:0] adc_hs_value,
  output logic             ph_valid,
  output logic             hs_valid,
  input  logic [VAL_W-1:0] adc_setpoint,
  output logic             below,
  output logic             timeout_err,
  output logic             overrun_err
);

  localparam int unsigned ACC_W   = ADC_W + AVG_LOG2;
  localparam int unsigned NSAMP   = 1 << AVG_LOG2;
  localparam int unsigned NS_W    = AVG_LOG2 + 1;
  localparam int unsigned SET_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned RND_W   = (HS_EVERY > 1) ? $clog2(HS_EVERY) : 1;

  state_e state, state_d;

  logic             tick;
  logic [RND_W-1:0] round_cnt;
  logic [SET_W-1:0] set_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [ACC_W-1:0] acc;
  logic [NS_W-1:0]  nsamp;

  logic             ch_next_c;
  logic             round_last_c;
  logic             last_sample_c;
  logic             to_expire_c;
  logic             settle_done_c;
  logic [VAL_W-1:0] avg_c;
  logic [VAL_W-1:0] thr_c;

  logic             round_adv_c;
  logic             chsel_ld_c;
  logic             start_c;
  logic             acc_add_c;
  logic             acc_clr_c;
  logic             publish_c;
  logic             timeout_set_c;
  logic             overrun_set_c;

  adc_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick (
    .clk48mhz (clk48mhz),
    .rstn     (rstn),
    .tick     (tick)
  );

  // round decode, termination conditions and result arithmetic
  assign round_last_c  = (round_cnt == RND_W'(HS_EVERY - 1));
  assign ch_next_c     = round_last_c ? CH_HS : CH_PH;
  assign last_sample_c = (nsamp == NS_W'(NSAMP - 1));
  assign to_expire_c   = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign settle_done_c = (set_cnt == SET_W'(SETTLE_CYC - 1));
  assign avg_c         = VAL_W'(acc >> AVG_LOG2);
  assign thr_c         = sat_add(adc_setpoint, VAL_W'(HYST));

  // state register
  always_ff @(posedge clk48mhz or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // next-state logic; conv_done takes priority over a coincident timeout
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (tick && enable) begin
          state_d = (ch_next_c != adc_chsel) ? SETTLE : START;
        end
      end
      SETTLE: begin
        if (settle_done_c) begin
          state_d = START;
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (conv_done) begin
          state_d = last_sample_c ? PUBLISH : START;
        end else if (to_expire_c) begin
          state_d = IDLE;
        end
      end
      PUBLISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // per-state control strobes for the datapath
  always_comb begin
    round_adv_c   = 1'b0;
    chsel_ld_c    = 1'b0;
    start_c       = 1'b0;
    acc_add_c     = 1'b0;
    acc_clr_c     = 1'b0;
    publish_c     = 1'b0;
    timeout_set_c = 1'b0;
    overrun_set_c = tick && (state != IDLE);
    unique case (state)
      IDLE: begin
        if (tick && enable) begin
          round_adv_c = 1'b1;
          chsel_ld_c  = (ch_next_c != adc_chsel);
        end
      end
      SETTLE: begin
      end
      START: begin
        start_c = 1'b1;
      end
      WAIT: begin
        if (conv_done) begin
          acc_add_c = 1'b1;
        end else if (to_expire_c) begin
          timeout_set_c = 1'b1;
          acc_clr_c     = 1'b1;
        end
      end
      PUBLISH: begin
        publish_c = 1'b1;
        acc_clr_c = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // round counter, channel select and phase counters
  always_ff @(posedge clk48mhz or negedge rstn) begin
    if (!rstn) begin
      round_cnt <= '0;
      adc_chsel <= CH_PH;
      set_cnt   <= '0;
      to_cnt    <= '0;
    end else begin
      if (round_adv_c) begin
        round_cnt <= round_last_c ? '0 : round_cnt + RND_W'(1);
      end
      if (chsel_ld_c) begin
        adc_chsel <= ch_next_c;
      end
      // both counters only run in their own state, so START restarts the timeout
      set_cnt <= (state == SETTLE) ? set_cnt + SET_W'(1) : '0;
      to_cnt  <= (state == WAIT)   ? to_cnt + TO_W'(1)   : '0;
    end
  end

  // sample accumulator
  always_ff @(posedge clk48mhz or negedge rstn) begin
    if (!rstn) begin
      acc   <= '0;
      nsamp <= '0;
    end else if (acc_add_c) begin
      acc   <= acc + ACC_W'(conv_data);
      nsamp <= nsamp + NS_W'(1);
    end else if (acc_clr_c) begin
      acc   <= '0;
      nsamp <= '0;
    end
  end

  // start pulse, published results, heater demand and sticky flags
  always_ff @(posedge clk48mhz or negedge rstn) begin
    if (!rstn) begin
      conv_start   <= 1'b0;
      adc_value    <= '0;
      adc_hs_value <= '0;
      ph_valid     <= 1'b0;
      hs_valid     <= 1'b0;
      below        <= 1'b0;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      conv_start <= start_c;
      ph_valid   <= publish_c && (adc_chsel == CH_PH);
      hs_valid   <= publish_c && (adc_chsel == CH_HS);
      if (publish_c && (adc_chsel == CH_PH)) begin
        adc_value <= avg_c;
        if (avg_c < adc_setpoint) begin
          below <= 1'b1;
        end else if (avg_c >= thr_c) begin
          below <= 1'b0;
        end
      end
      if (publish_c && (adc_chsel == CH_HS)) begin
        adc_hs_value <= avg_c;
      end
      // a new error in the same cycle as err_clr keeps the flag set
      timeout_err <= timeout_set_c | (timeout_err & ~err_clr);
      overrun_err <= overrun_set_c | (overrun_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
`timescale 1ns/1ps
module tb_adc_scan_ctrl;

  logic        clk48mhz = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        err_clr = 1'b0;
  logic        conv_done = 1'b0;
  logic [11:0] conv_data = '0;
  logic [15:0] adc_setpoint = '0;
  logic        conv_start;
  logic        adc_chsel;
  logic [15:0] adc_value;
  logic [15:0] adc_hs_value;
  logic        ph_valid;
  logic        hs_valid;
  logic        below;
  logic        timeout_err;
  logic        overrun_err;

  int tests = 0;
  int fails = 0;
  int cyc;
  int delay = 20;
  bit withhold = 1'b0;
  int pend = 0;
  logic [11:0] data_q[$];

  adc_scan_ctrl #(
    .SAMPLE_DIV (100),
    .AVG_LOG2   (2),
    .SETTLE_CYC (4),
    .TIMEOUT_CYC(64),
    .HS_EVERY   (2),
    .HYST       (16)
  ) dut (
    .clk48mhz     (clk48mhz),
    .rstn         (rstn),
    .enable       (enable),
    .err_clr      (err_clr),
    .conv_start   (conv_start),
    .conv_done    (conv_done),
    .conv_data    (conv_data),
    .adc_chsel    (adc_chsel),
    .adc_value    (adc_value),
    .adc_hs_value (adc_hs_value),
    .ph_valid     (ph_valid),
    .hs_valid     (hs_valid),
    .adc_setpoint (adc_setpoint),
    .below        (below),
    .timeout_err  (timeout_err),
    .overrun_err  (overrun_err)
  );

  always #10 clk48mhz = ~clk48mhz;

  // posedges since reset release; the divider ticks when cyc is a multiple of 100
  always @(posedge clk48mhz or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // shifter model: conv_done 'delay' cycles after the cycle conv_start is high
  always @(negedge clk48mhz) begin
    conv_done = 1'b0;
    if (!rstn) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          conv_done = 1'b1;
          conv_data = (data_q.size() > 0) ? data_q.pop_front() : 12'd0;
        end
      end
      if (conv_start && !withhold) pend = delay;
    end
  end

  task automatic push4(input logic [11:0] a, input logic [11:0] b,
                       input logic [11:0] c, input logic [11:0] d);
    data_q.push_back(a);
    data_q.push_back(b);
    data_q.push_back(c);
    data_q.push_back(d);
  endtask

  // enable one round, then watch it for ncyc cycles from its first conv_start
  task automatic run_round(input int ncyc, output bit found, output int start_cyc,
                           output int n_start, output int n_ph, output int n_hs,
                           output logic ch_start, output bit ch_moved);
    found = 1'b0;
    n_start = 0; n_ph = 0; n_hs = 0; ch_moved = 1'b0; start_cyc = -1;
    enable = 1'b1;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk48mhz);
      if (conv_start) found = 1'b1;
    end
    enable = 1'b0;
    start_cyc = cyc;
    ch_start = adc_chsel;
    n_start = found ? 1 : 0;
    if (found) begin
      for (int i = 0; i < ncyc; i++) begin
        @(negedge clk48mhz);
        if (conv_start) n_start++;
        if (ph_valid) n_ph++;
        if (hs_valid) n_hs++;
        if (adc_chsel !== ch_start) ch_moved = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk48mhz);
    tests++;
    if ({conv_start, adc_chsel, ph_valid, hs_valid, below, timeout_err, overrun_err} !== 7'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b, expected 0000000",
               {conv_start, adc_chsel, ph_valid, hs_valid, below, timeout_err, overrun_err});
    end
    tests++;
    if ({adc_value, adc_hs_value} !== 32'h0) begin
      fails++;
      $display("FAIL reset_values: got %h/%h, expected 0/0", adc_value, adc_hs_value);
    end
    rstn = 1'b1;
    @(negedge clk48mhz);
    tests++;
    if (conv_start !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_start: got %b, expected 0", conv_start);
    end
  endtask

  task automatic test_ph_round();
    bit found; int sc, ns, nph, nhs; logic ch; bit moved;
    adc_setpoint = 16'd0;
    push4(12'd100, 12'd102, 12'd104, 12'd106);
    run_round(150, found, sc, ns, nph, nhs, ch, moved);
    tests++;
    if (found !== 1'b1 || (sc % 100) != 2) begin
      fails++;
      $display("FAIL ph_start_lag: found=%0d lag=%0d, expected found=1 lag=2", found, sc % 100);
    end
    tests++;
    if (ns != 4 || nph != 1 || nhs != 0) begin
      fails++;
      $display("FAIL ph_counts: starts=%0d ph=%0d hs=%0d, expected 4/1/0", ns, nph, nhs);
    end
    tests++;
    if (ch !== 1'b0 || moved) begin
      fails++;
      $display("FAIL ph_chsel: chsel=%b moved=%0d, expected 0 and steady", ch, moved);
    end
    tests++;
    if (adc_value !== 16'd103 || below !== 1'b0) begin
      fails++;
      $display("FAIL ph_value: value=%0d below=%b, expected 103/0", adc_value, below);
    end
  endtask

  task automatic test_alternation();
    bit found; int sc, ns, nph, nhs; logic ch; bit moved;
    logic [11:0] d[3][4];
    logic [15:0] exp_ph[3];
    logic [15:0] exp_hs[3];
    logic        exp_ch[3];
    d[0] = '{12'd200, 12'd200, 12'd200, 12'd204}; exp_ch[0] = 1'b1; exp_ph[0] = 16'd103; exp_hs[0] = 16'd201;
    d[1] = '{12'd300, 12'd300, 12'd300, 12'd300}; exp_ch[1] = 1'b0; exp_ph[1] = 16'd300; exp_hs[1] = 16'd201;
    d[2] = '{12'd4000, 12'd4001, 12'd4002, 12'd4003}; exp_ch[2] = 1'b1; exp_ph[2] = 16'd300; exp_hs[2] = 16'd4001;
    for (int r = 0; r < 3; r++) begin
      push4(d[r][0], d[r][1], d[r][2], d[r][3]);
      run_round(150, found, sc, ns, nph, nhs, ch, moved);
      tests++;
      if (found !== 1'b1 || (sc % 100) != 6) begin
        fails++;
        $display("FAIL alt%0d_lag: found=%0d lag=%0d, expected 1/6", r, found, sc % 100);
      end
      tests++;
      if (ch !== exp_ch[r] || moved || nph != (exp_ch[r] ? 0 : 1) || nhs != (exp_ch[r] ? 1 : 0)) begin
        fails++;
        $display("FAIL alt%0d_channel: chsel=%b moved=%0d ph=%0d hs=%0d, expected chsel=%b",
                 r, ch, moved, nph, nhs, exp_ch[r]);
      end
      tests++;
      if (adc_value !== exp_ph[r] || adc_hs_value !== exp_hs[r]) begin
        fails++;
        $display("FAIL alt%0d_values: ph=%0d hs=%0d, expected %0d/%0d",
                 r, adc_value, adc_hs_value, exp_ph[r], exp_hs[r]);
      end
    end
  endtask

  task automatic test_hysteresis();
    bit found; int sc, ns, nph, nhs; logic ch; bit moved;
    logic [15:0] sp[5]   = '{16'd500, 16'd500, 16'd500, 16'd500, 16'hFFF8};
    logic [11:0] av[5]   = '{12'd499, 12'd510, 12'd516, 12'd505, 12'd4095};
    logic        expb[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      adc_setpoint = sp[i];
      push4(av[i], av[i], av[i], av[i]);
      run_round(150, found, sc, ns, nph, nhs, ch, moved);
      tests++;
      if (found !== 1'b1 || nph != 1 || adc_value !== 16'(av[i]) || below !== expb[i]) begin
        fails++;
        $display("FAIL hyst%0d: found=%0d ph=%0d value=%0d below=%b, expected value=%0d below=%b",
                 i, found, nph, adc_value, below, av[i], expb[i]);
      end
      // heatsink round with a low average must not touch below
      push4(12'd0, 12'd0, 12'd0, 12'd0);
      run_round(150, found, sc, ns, nph, nhs, ch, moved);
      tests++;
      if (found !== 1'b1 || nhs != 1 || below !== expb[i]) begin
        fails++;
        $display("FAIL hyst%0d_hs_hold: found=%0d hs=%0d below=%b, expected below=%b",
                 i, found, nhs, below, expb[i]);
      end
    end
  endtask

  task automatic test_timeout();
    bit found; int sc, ns, nph, nhs; logic ch; bit moved;
    int n_st, n_v;
    withhold = 1'b1;
    found = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk48mhz);
      if (conv_start) found = 1'b1;
    end
    enable = 1'b0;
    n_st = 0; n_v = 0;
    repeat (63) begin
      @(negedge clk48mhz);
      if (conv_start) n_st++;
      if (ph_valid || hs_valid) n_v++;
    end
    tests++;
    if (found !== 1'b1 || timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_early: found=%0d timeout_err=%b, expected 1/0", found, timeout_err);
    end
    @(negedge clk48mhz);
    tests++;
    if (timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_set: timeout_err=%b, expected 1 at 64 cycles", timeout_err);
    end
    repeat (50) begin
      @(negedge clk48mhz);
      if (conv_start) n_st++;
      if (ph_valid || hs_valid) n_v++;
    end
    withhold = 1'b0;
    tests++;
    if (n_st != 0 || n_v != 0) begin
      fails++;
      $display("FAIL timeout_quiet: extra starts=%0d strobes=%0d, expected 0/0", n_st, n_v);
    end
    // the lost printhead round still consumed its slot: next is heatsink
    push4(12'd7, 12'd7, 12'd7, 12'd7);
    run_round(150, found, sc, ns, nph, nhs, ch, moved);
    tests++;
    if (found !== 1'b1 || ch !== 1'b1 || nhs != 1 || adc_hs_value !== 16'd7 || timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_next: found=%0d chsel=%b hs=%0d hs_value=%0d err=%b, expected 1/1/1/7/1",
               found, ch, nhs, adc_hs_value, timeout_err);
    end
    err_clr = 1'b1;
    @(negedge clk48mhz);
    err_clr = 1'b0;
    tests++;
    if (timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_clr: timeout_err=%b, expected 0", timeout_err);
    end
  endtask

  task automatic test_overrun();
    bit found; int sc, ns, nph, nhs; logic ch; bit moved;
    tests++;
    if (overrun_err !== 1'b0) begin
      fails++;
      $display("FAIL overrun_pre: overrun_err=%b, expected 0", overrun_err);
    end
    delay = 40;
    push4(12'd40, 12'd44, 12'd48, 12'd52);
    run_round(250, found, sc, ns, nph, nhs, ch, moved);
    delay = 20;
    tests++;
    if (found !== 1'b1 || ns != 4 || nph != 1 || adc_value !== 16'd46) begin
      fails++;
      $display("FAIL overrun_round: found=%0d starts=%0d ph=%0d value=%0d, expected 1/4/1/46",
               found, ns, nph, adc_value);
    end
    tests++;
    if (overrun_err !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: overrun_err=%b, expected 1", overrun_err);
    end
    err_clr = 1'b1;
    @(negedge clk48mhz);
    err_clr = 1'b0;
    tests++;
    if (overrun_err !== 1'b0) begin
      fails++;
      $display("FAIL overrun_clr: overrun_err=%b, expected 0", overrun_err);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit found; int sc, ns, nph, nhs; logic ch; bit moved;
    int n_st;
    push4(12'd9, 12'd9, 12'd9, 12'd9);
    found = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk48mhz);
      if (conv_start) found = 1'b1;
    end
    enable = 1'b0;
    repeat (5) @(negedge clk48mhz);
    rstn = 1'b0;
    #1;
    tests++;
    if (found !== 1'b1 ||
        {conv_start, adc_chsel, ph_valid, hs_valid, below, timeout_err, overrun_err} !== 7'b0 ||
        {adc_value, adc_hs_value} !== 32'h0) begin
      fails++;
      $display("FAIL midwait_reset: found=%0d flags=%b value=%0d hs=%0d, expected all 0",
               found, {conv_start, adc_chsel, ph_valid, hs_valid, below, timeout_err, overrun_err},
               adc_value, adc_hs_value);
    end
    n_st = 0;
    repeat (3) begin
      @(negedge clk48mhz);
      if (conv_start) n_st++;
    end
    data_q.delete();
    rstn = 1'b1;
    push4(12'd1, 12'd2, 12'd3, 12'd4);
    run_round(150, found, sc, ns, nph, nhs, ch, moved);
    tests++;
    if (n_st != 0 || found !== 1'b1 || sc != 102) begin
      fails++;
      $display("FAIL midwait_restart: starts_in_reset=%0d found=%0d first_start_cyc=%0d, expected 0/1/102",
               n_st, found, sc);
    end
    tests++;
    if (ch !== 1'b0 || nph != 1 || adc_value !== 16'd2) begin
      fails++;
      $display("FAIL midwait_round: chsel=%b ph=%0d value=%0d, expected 0/1/2", ch, nph, adc_value);
    end
  endtask

  initial begin
    test_reset();
    test_ph_round();
    test_alternation();
    test_hysteresis();
    test_timeout();
    test_overrun();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Conversion scheduler for the printhead temperature ADC. It paces conversions from a fixed-rate tick and shares the single ADC between the printhead and heatsink channels, with the heatsink sampled once every `HS_EVERY` rounds. It sequences the SPI shifter through a start/done handshake, averages `2**AVG_LOG2` samples per round and publishes per-channel results. It also drives the hysteretic `below` heater-demand flag against `adc_setpoint`.

## Interface
- `SAMPLE_DIV`, 48000: clk48mhz cycles per scan tick (1 kHz).
- `AVG_LOG2`, 2: log2 of the number of samples averaged per round.
- `SETTLE_CYC`, 96: wait cycles after an `adc_chsel` change, before start.
- `TIMEOUT_CYC`, 1024: maximum cycles from `conv_start` to `conv_done`.
- `HS_EVERY`, 8: rounds per heatsink round; the other rounds are printhead.
- `HYST`, 16: hysteresis added to the setpoint for clearing `below`.

Ports:
- `clk48mhz` in 1: the single clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `enable` in 1: scan enable.
- `err_clr` in 1: clears the sticky flags.
- `conv_start` out 1: one-cycle start pulse to the SPI shifter.
- `conv_done` in 1: one-cycle pulse from the shifter; `conv_data` is valid with it.
- `conv_data` in 12: raw ADC code.
- `adc_chsel` out 1: 0 = printhead, 1 = heatsink.
- `adc_value` out 16: printhead average.
- `adc_hs_value` out 16: heatsink average.
- `ph_valid`, `hs_valid` out 1: one-cycle update strobes.
- `adc_setpoint` in 16: printhead threshold.
- `below` out 1: heater demand.
- `timeout_err`, `overrun_err` out 1: sticky error flags.

## Operation
- FSM states: IDLE, SETTLE, START, WAIT, PUBLISH.
- IDLE: when `tick` arrives and `enable` is high, pick the channel. The round counter counts 0..HS_EVERY-1. At count HS_EVERY-1 the channel is heatsink, otherwise printhead. The counter wraps to 0.
  - If the channel differs from the current `adc_chsel`: update `adc_chsel` and go to SETTLE.
  - Otherwise go to START.
- SETTLE: count SETTLE_CYC cycles, then go to START.
- START: assert `conv_start` for one cycle, clear the timeout counter, then go to WAIT.
- WAIT:
  - On `conv_done`: add `conv_data` to the accumulator (12+AVG_LOG2 bits) and increment the sample count.
    - If the count reaches 2**AVG_LOG2, go to PUBLISH.
    - Otherwise go to START. There is no re-settle between samples.
  - On timeout expiry without `conv_done`: set `timeout_err`, discard the accumulator and go to IDLE. The round is lost and the round counter is not rewound.
  - If `conv_done` and timeout expiry occur in the same cycle, `conv_done` wins.
- PUBLISH: compute avg = accumulator >> AVG_LOG2, zero-extended to 16 bits. Write it to the selected channel's register and pulse its valid strobe. Clear the accumulator, then go to IDLE.
- `below` is updated only on printhead publish:
  - set when avg < `adc_setpoint`;
  - cleared when avg >= `adc_setpoint` + HYST, with the sum saturating at 16'hFFFF;
  - otherwise held.
- Overrun: a `tick` arriving outside IDLE is dropped and sets `overrun_err`.
- `conv_done` outside WAIT is ignored.
- `enable` is sampled only in IDLE. A round already in flight completes.
- `err_clr` clears both sticky flags. If `err_clr` and a new error occur in the same cycle, the error wins.
- Tick divider: free-running 0..SAMPLE_DIV-1; `tick` is asserted at the wrap.

## Timing
- Reset values:
  - all outputs 0;
  - `adc_chsel` = 0 (printhead);
  - FSM in IDLE;
  - tick and round counters at 0.
- Reset is effective mid-round. `conv_start` is never asserted during or in the cycle after reset.
- Registered outputs; no combinational input-to-output paths.
- Pulse timing from the IDLE tick:
  - `conv_start` is asserted 2 cycles after the tick with no channel change.
  - With a channel change it is asserted SETTLE_CYC+2 cycles after the tick.
- Result timing:
  - the value, `ph_valid`/`hs_valid` and `below` all update on the edge leaving PUBLISH;
  - the final `conv_done` reaches PUBLISH one cycle later, so results appear 2 cycles after the final `conv_done`.
- Each sample starts one cycle after the previous `conv_done`.

## Structure
- Package `adc_pkg`:
  - state enum;
  - `CH_PH`=0, `CH_HS`=1;
  - `ADC_W`=12, `VAL_W`=16.
- Sub-module `adc_tick_gen`: the SAMPLE_DIV divider, which produces `tick`.
- The FSM, accumulator, round counter, result registers, hysteresis compare and error flags live in the top level.

## Test plan
Bench parameters: SAMPLE_DIV=100, AVG_LOG2=2, SETTLE_CYC=4, TIMEOUT_CYC=64, HS_EVERY=2, HYST=16. The shifter model answers `conv_done` 20 cycles after `conv_start`.
- Printhead round: `conv_data` = 100, 102, 104, 106 -> `adc_value`=103, one `ph_valid` pulse, `adc_chsel`=0 throughout.
- Alternation over 4 ticks: channel sequence PH, HS, PH, HS. `conv_start` lags the tick by 6 cycles on each change. `adc_hs_value` holds the heatsink average; `adc_value` is unchanged by heatsink rounds.
- Hysteresis with setpoint 500: PH avg 499 -> `below`=1. Avg 510 -> stays 1. Avg 516 -> 0. Avg 505 -> stays 0. Setpoint 16'hFFF8 with avg 4095 -> `below`=1 (saturation path).
- Timeout: the model withholds `conv_done` -> `timeout_err` set 64 cycles after `conv_start`, no valid strobe, FSM back in IDLE. `err_clr` -> flag low.
- Overrun: the model delay is raised to 40 with SAMPLE_DIV=100 (one round takes over 160 cycles) -> `overrun_err` set and rounds still complete.
- Reset asserted mid-WAIT -> all outputs 0 immediately. After release, the first `conv_start` follows the first tick.
